muldiv_unit: RTL

- Iterative RV32M multiply/divide unit in the execute path of the RISC-V core.
- Consumes the two register-file read operands (RD1, RD2) and produces a 32-bit result with a destination index and write strobe. These drive the register file's write port (WD3, A3, WE).
- Runs one radix-2 step per cycle with a fixed latency, so the control path stalls on a simple start/busy/done handshake.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// opcode encodings, FSM state encoding and small opcode decode helpers.
package muldiv_pkg;

    localparam int DEFAULT_XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // rs1 is treated as signed by MULH, MULHSU, DIV and REM
    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is treated as signed by MULH, DIV and REM
    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // funct3[2] separates the divide family from the multiply family
    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes on
// acceptance, one radix-2 step runs per cycle for ITER cycles (shift-add multiply
// or restoring divide on a shared 64-bit shift register), then a single fix-up
// cycle applies sign correction and the divide special cases before a one-cycle
// done/we pulse.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN,
    parameter int ITER = XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            we
);

    localparam int CW = $clog2(ITER) + 1;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};

    state_t            state_reg, state_next;
    logic [2:0]        op_reg;
    logic [4:0]        rd_reg;
    logic [CW-1:0]     cnt_reg;
    // mul: {product_hi, multiplier/product_lo}; div: {remainder, dividend/quotient}
    logic [2*XLEN-1:0] acc_reg;
    // multiplicand magnitude for mul, divisor magnitude for div
    logic [XLEN-1:0]   opnd_reg;
    logic [XLEN-1:0]   a_orig_reg;
    logic              neg_a_reg, neg_b_reg;
    logic              div_zero_reg, ovf_reg;
    logic [XLEN-1:0]   result_reg;
    logic [4:0]        rd_out_reg;

    // operand conditioning at acceptance
    logic              neg_a_in, neg_b_in;
    logic [XLEN-1:0]   mag_a, mag_b;

    // iteration datapath
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;

    // fix-up datapath
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

    assign neg_a_in = op_a_signed(funct3) & a[XLEN-1];
    assign neg_b_in = op_b_signed(funct3) & b[XLEN-1];
    assign mag_a    = neg_a_in ? (~a + 1'b1) : a;
    assign mag_b    = neg_b_in ? (~b + 1'b1) : b;

    // one radix-2 step for both multiply (shift-add) and divide (restoring)
    always_comb begin
        mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, opnd_reg};
        mul_next = acc_reg[0] ? {mul_sum, acc_reg[XLEN-1:1]}
                              : {1'b0, acc_reg[2*XLEN-1:1]};
        // the shifted partial remainder is below twice the divisor, so bit XLEN
        // of the 33-bit difference is a reliable "trial went negative" flag
        rem_sh   = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
        div_diff = rem_sh - {1'b0, opnd_reg};
        div_next = !div_diff[XLEN] ? {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1}
                                   : {rem_sh[XLEN-1:0],   acc_reg[XLEN-2:0], 1'b0};
    end

    // sign correction, result selection and divide special-case overrides
    always_comb begin
        prod_fix = (neg_a_reg ^ neg_b_reg) ? (~acc_reg + 1'b1) : acc_reg;
        quo_fix  = (neg_a_reg ^ neg_b_reg) ? (~acc_reg[XLEN-1:0] + 1'b1) : acc_reg[XLEN-1:0];
        rem_fix  = neg_a_reg ? (~acc_reg[2*XLEN-1:XLEN] + 1'b1) : acc_reg[2*XLEN-1:XLEN];
        fix_result = '0;
        case (op_reg)
            OP_MUL:                       fix_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_result = quo_fix;
            default:                      fix_result = rem_fix;
        endcase
        if (op_is_div(op_reg) && div_zero_reg) begin
            fix_result = op_reg[1] ? a_orig_reg : ONES;
        end else if (op_is_div(op_reg) && ovf_reg) begin
            fix_result = op_reg[1] ? '0 : SMIN;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // next-state and handshake outputs
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (cnt_reg == CW'(ITER - 1)) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                busy       = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // operand capture, iteration and result registration
    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg       <= '0;
            rd_reg       <= '0;
            cnt_reg      <= '0;
            acc_reg      <= '0;
            opnd_reg     <= '0;
            a_orig_reg   <= '0;
            neg_a_reg    <= 1'b0;
            neg_b_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            ovf_reg      <= 1'b0;
            result_reg   <= '0;
            rd_out_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        op_reg       <= funct3;
                        rd_reg       <= rd_in;
                        cnt_reg      <= '0;
                        a_orig_reg   <= a;
                        neg_a_reg    <= neg_a_in;
                        neg_b_reg    <= neg_b_in;
                        div_zero_reg <= (b == '0);
                        ovf_reg      <= op_b_signed(funct3) && (a == SMIN) && (b == ONES);
                        if (op_is_div(funct3)) begin
                            acc_reg  <= {{XLEN{1'b0}}, mag_a};
                            opnd_reg <= mag_b;
                        end else begin
                            acc_reg  <= {{XLEN{1'b0}}, mag_b};
                            opnd_reg <= mag_a;
                        end
                    end
                end
                ST_RUN: begin
                    acc_reg <= op_is_div(op_reg) ? div_next : mul_next;
                    cnt_reg <= cnt_reg + 1'b1;
                end
                ST_FIX: begin
                    result_reg <= fix_result;
                    rd_out_reg <= rd_reg;
                end
                default: ;
            endcase
        end
    end

    assign result = result_reg;
    assign rd_out = rd_out_reg;
    assign we     = done;

endmodule
